imm_gen_stage: RTL and testbench

Registered, handshaked immediate-generation stage between instruction fetch and decode. It classifies the instruction format from the opcode itself rather than taking an external select, and produces the immediate sign-extended to XLEN. It adds an illegal-opcode flag and, optionally, a precomputed PC-relative target. It supports all base formats (I, S, B, U, J, R), RV32 and RV64, and full-throughput valid/ready flow control through a two-entry skid buffer.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_extract.sv | 58 +++++
 rtl/imm_gen_stage.sv | 125 ++++++++++++
 tb/tb_imm_gen_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format codes and the
// RV32/RV64 base opcodes the extractor recognises.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction classifier: opcode -> format, sign-extended
// immediate and illegal flag. The *W opcodes are only legal at XLEN=64.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [31:0] raw;

    // Classify the opcode; anything unrecognised reads as R with illegal set.
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
                OP_STORE:         fmt = FMT_S;
                OP_BRANCH:        fmt = FMT_B;
                OP_LUI, OP_AUIPC: fmt = FMT_U;
                OP_JAL:           fmt = FMT_J;
                OP_OP:            fmt = FMT_R;
                OP_IMM_32: begin
                    if (XLEN == 64) fmt = FMT_I;
                    else            illegal = 1'b1;
                end
                OP_32: begin
                    if (XLEN != 64) illegal = 1'b1;
                end
                default:          illegal = 1'b1;
            endcase
        end
    end

    // Assemble the 32-bit signed immediate for the detected format.
    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I: raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: raw = {instr[31:12], 12'h000};
            FMT_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    // Signed size cast sign-extends to XLEN (no-op at XLEN=32).
    assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready handshake and a
// one-deep skid register so in_ready never depends combinationally on
// out_ready. Optional feature macro: IMM_PC_TARGET_EN adds out_target
// (pc + imm for B, J and AUIPC, zero otherwise).
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_PC_TARGET_EN
    ,
    output logic [XLEN-1:0] out_target
`endif
);

    fmt_e            x_fmt;
    logic [XLEN-1:0] x_imm;
    logic            x_illegal;

    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .fmt     (x_fmt),
        .imm     (x_imm),
        .illegal (x_illegal)
    );

`ifdef IMM_PC_TARGET_EN
    logic [XLEN-1:0] x_target;
    logic [XLEN-1:0] skid_target;

    // PC-relative target only for control-flow formats and AUIPC.
    always_comb begin
        x_target = '0;
        if (x_fmt == FMT_B || x_fmt == FMT_J || in_instr[6:0] == OP_AUIPC)
            x_target = in_pc + x_imm;
    end
`endif

    // Skid register being full is the only reason to stall upstream.
    assign in_ready = ~skid_valid;

    // Output/skid register update: reset, then flush, then normal flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_fmt      <= FMT_R;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_R;
            skid_illegal <= 1'b0;
`ifdef IMM_PC_TARGET_EN
            out_target   <= '0;
            skid_target  <= '0;
`endif
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output slot frees up: skid drains first to keep order.
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_instr   <= skid_instr;
                out_pc      <= skid_pc;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
`ifdef IMM_PC_TARGET_EN
                out_target  <= skid_target;
`endif
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_instr   <= in_instr;
                    out_pc      <= in_pc;
                    out_imm     <= x_imm;
                    out_fmt     <= x_fmt;
                    out_illegal <= x_illegal;
`ifdef IMM_PC_TARGET_EN
                    out_target  <= x_target;
`endif
                end
            end
        end else if (in_valid && !skid_valid) begin
            // Output is stalled: park the new entry in the skid register.
            skid_valid   <= 1'b1;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
            skid_imm     <= x_imm;
            skid_fmt     <= x_fmt;
            skid_illegal <= x_illegal;
`ifdef IMM_PC_TARGET_EN
            skid_target  <= x_target;
`endif
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are checked against a queue-based reference of accepted entries.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        r32, v32, ill32, r64, v64, ill64;
    logic [31:0] instr32, pc32, imm32, tgt32, instr64;
    logic [63:0] pc64, imm64, tgt64;
    logic [2:0]  fmt32, fmt64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) d32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_instr(instr32), .out_pc(pc32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
`ifdef IMM_PC_TARGET_EN
        , .out_target(tgt32)
`endif
    );

    imm_gen_stage #(.XLEN(64)) d64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_instr(instr64), .out_pc(pc64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
`ifdef IMM_PC_TARGET_EN
        , .out_target(tgt64)
`endif
    );

`ifndef IMM_PC_TARGET_EN
    assign tgt32 = '0;
    assign tgt64 = '0;
`endif

    typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;

    ent_t        q[$];
    logic [31:0] emit_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          last_acc;

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        if (v[bits-1]) return v - (64'd1 << bits);
        return v;
    endfunction

    // Reference decode straight from the opcode table and bit layouts.
    function automatic void model(input logic [31:0] i, input int xl,
                                  output logic [2:0] f, output logic [63:0] imm,
                                  output logic ill);
        f = 3'd0; imm = '0; ill = 1'b0;
        if (i[1:0] != 2'b11) ill = 1'b1;
        else case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin f = 3'd1; imm = sx(64'(i[31:20]), 12); end
            7'h23: begin f = 3'd2; imm = sx(64'({i[31:25], i[11:7]}), 12); end
            7'h63: begin f = 3'd3; imm = sx(64'({i[31], i[7], i[30:25], i[11:8]}) * 2, 13); end
            7'h37, 7'h17: begin f = 3'd4; imm = sx(64'(i[31:12]) * 4096, 32); end
            7'h6F: begin f = 3'd5; imm = sx(64'({i[31], i[19:12], i[20], i[30:21]}) * 2, 21); end
            7'h33: f = 3'd0;
            7'h1B: if (xl == 64) begin f = 3'd1; imm = sx(64'(i[31:20]), 12); end else ill = 1'b1;
            7'h3B: if (xl != 64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        if (xl == 32) imm[63:32] = '0;
    endfunction

    function automatic logic [63:0] model_tgt(input logic [31:0] i, input logic [63:0] pc, input int xl);
        logic [2:0] f; logic [63:0] imm, t; logic ill;
        model(i, xl, f, imm, ill);
        t = (f == 3'd3 || f == 3'd5 || i[6:0] == 7'h17) ? pc + imm : 64'd0;
        if (xl == 32) t[63:32] = '0;
        return t;
    endfunction

    // One clock: check handshake/payload before the edge, update reference after.
    task automatic cycle();
        logic [2:0] f; logic [63:0] e, t; logic il; ent_t h; bit acc, emt;
        @(negedge clk);
        n_cmp += 4;
        if (r32 !== (q.size() < 2)) begin n_err++; $display("FAIL in_ready32 got %b want %b", r32, q.size() < 2); end
        if (r64 !== (q.size() < 2)) begin n_err++; $display("FAIL in_ready64 got %b want %b", r64, q.size() < 2); end
        if (v32 !== (q.size() > 0)) begin n_err++; $display("FAIL out_valid32 got %b want %b", v32, q.size() > 0); end
        if (v64 !== (q.size() > 0)) begin n_err++; $display("FAIL out_valid64 got %b want %b", v64, q.size() > 0); end
        acc = in_valid && (q.size() < 2);
        emt = out_ready && (q.size() > 0);
        if (q.size() > 0) begin
            h = q[0];
            model(h.instr, 32, f, e, il);
            t = model_tgt(h.instr, h.pc, 32);
            n_cmp += 6;
            if (instr32 !== h.instr)     begin n_err++; $display("FAIL instr32 got %h want %h", instr32, h.instr); end
            if (pc32 !== h.pc[31:0])     begin n_err++; $display("FAIL pc32 got %h want %h", pc32, h.pc[31:0]); end
            if (fmt32 !== f)             begin n_err++; $display("FAIL fmt32 instr %h got %0d want %0d", h.instr, fmt32, f); end
            if (imm32 !== e[31:0])       begin n_err++; $display("FAIL imm32 instr %h got %h want %h", h.instr, imm32, e[31:0]); end
            if (ill32 !== il)            begin n_err++; $display("FAIL illegal32 instr %h got %b want %b", h.instr, ill32, il); end
`ifdef IMM_PC_TARGET_EN
            if (tgt32 !== t[31:0])       begin n_err++; $display("FAIL target32 instr %h got %h want %h", h.instr, tgt32, t[31:0]); end
`else
            if (tgt32 !== 32'd0)         begin n_err++; $display("FAIL target32 tie got %h want 0", tgt32); end
`endif
            model(h.instr, 64, f, e, il);
            t = model_tgt(h.instr, h.pc, 64);
            n_cmp += 6;
            if (instr64 !== h.instr)     begin n_err++; $display("FAIL instr64 got %h want %h", instr64, h.instr); end
            if (pc64 !== h.pc)           begin n_err++; $display("FAIL pc64 got %h want %h", pc64, h.pc); end
            if (fmt64 !== f)             begin n_err++; $display("FAIL fmt64 instr %h got %0d want %0d", h.instr, fmt64, f); end
            if (imm64 !== e)             begin n_err++; $display("FAIL imm64 instr %h got %h want %h", h.instr, imm64, e); end
            if (ill64 !== il)            begin n_err++; $display("FAIL illegal64 instr %h got %b want %b", h.instr, ill64, il); end
`ifdef IMM_PC_TARGET_EN
            if (tgt64 !== t)             begin n_err++; $display("FAIL target64 instr %h got %h want %h", h.instr, tgt64, t); end
`else
            if (tgt64 !== 64'd0)         begin n_err++; $display("FAIL target64 tie got %h want 0", tgt64); end
`endif
        end
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            if (emt) begin void'(q.pop_front()); emit_log.push_back(h.instr); end
            if (acc) q.push_back('{instr: in_instr, pc: in_pc});
        end
        last_acc = acc && !reset && !flush;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp += 8;
        if (v32 !== 1'b0 || v64 !== 1'b0) begin n_err++; $display("FAIL %s out_valid got %b/%b want 0", tag, v32, v64); end
        if (r32 !== 1'b1 || r64 !== 1'b1) begin n_err++; $display("FAIL %s in_ready got %b/%b want 1", tag, r32, r64); end
        if (instr32 !== 32'd0 || instr64 !== 32'd0) begin n_err++; $display("FAIL %s out_instr got %h/%h want 0", tag, instr32, instr64); end
        if (pc32 !== 32'd0 || pc64 !== 64'd0) begin n_err++; $display("FAIL %s out_pc got %h/%h want 0", tag, pc32, pc64); end
        if (imm32 !== 32'd0 || imm64 !== 64'd0) begin n_err++; $display("FAIL %s out_imm got %h/%h want 0", tag, imm32, imm64); end
        if (fmt32 !== 3'd0 || fmt64 !== 3'd0) begin n_err++; $display("FAIL %s out_fmt got %0d/%0d want 0", tag, fmt32, fmt64); end
        if (ill32 !== 1'b0 || ill64 !== 1'b0) begin n_err++; $display("FAIL %s out_illegal got %b/%b want 0", tag, ill32, ill64); end
        if (tgt32 !== 32'd0 || tgt64 !== 64'd0) begin n_err++; $display("FAIL %s out_target got %h/%h want 0", tag, tgt32, tgt64); end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_directed();
        logic [31:0] ins [8] = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'h001000EF,
                                 32'hFE000EE3, 32'h0000001B, 32'h00000090, 32'h002081B3};
        logic [2:0]  f32 [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd0, 3'd0, 3'd0};
        logic [31:0] i32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000800,
                                 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0};
        logic        l32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f64 [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd1, 3'd0, 3'd0};
        logic [63:0] i64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                                 64'h0000000000000800, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h0};
        logic        l64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_pc = 64'h1000;
        for (int k = 0; k < 8; k++) begin
            in_instr = ins[k];
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            n_cmp += 6;
            if (fmt32 !== f32[k]) begin n_err++; $display("FAIL dir_fmt32 %h got %0d want %0d", ins[k], fmt32, f32[k]); end
            if (imm32 !== i32[k]) begin n_err++; $display("FAIL dir_imm32 %h got %h want %h", ins[k], imm32, i32[k]); end
            if (ill32 !== l32[k]) begin n_err++; $display("FAIL dir_ill32 %h got %b want %b", ins[k], ill32, l32[k]); end
            if (fmt64 !== f64[k]) begin n_err++; $display("FAIL dir_fmt64 %h got %0d want %0d", ins[k], fmt64, f64[k]); end
            if (imm64 !== i64[k]) begin n_err++; $display("FAIL dir_imm64 %h got %h want %h", ins[k], imm64, i64[k]); end
            if (ill64 !== l64[k]) begin n_err++; $display("FAIL dir_ill64 %h got %b want %b", ins[k], ill64, l64[k]); end
`ifdef IMM_PC_TARGET_EN
            if (k == 3) begin
                n_cmp++;
                if (tgt32 !== 32'h1800 || tgt64 !== 64'h1800) begin
                    n_err++; $display("FAIL dir_jal_target got %h/%h want 1800", tgt32, tgt64);
                end
            end
`endif
        end
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [5] = '{32'h00100093, 32'h00200113, 32'h00000463, 32'h0000106F, 32'hABCDE537};
        int idx = 0;
        emit_log.delete();
        in_pc = 64'h2000;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = (idx < 5);
            in_instr = ins[idx];
            cycle();
            if (last_acc) idx++;
        end
        n_cmp += 2;
        if (idx != 2) begin n_err++; $display("FAIL bp_accepted got %0d want 2", idx); end
        if (r32 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full got %b want 0", r32); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && !(idx == 5 && q.size() == 0); k++) begin
            in_valid = (idx < 5);
            if (idx < 5) in_instr = ins[idx];
            cycle();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (idx != 5 || q.size() != 0) begin
            n_err++; $display("FAIL bp_drain_timeout accepted %0d pending %0d want 5/0", idx, q.size());
        end
        n_cmp++;
        if (emit_log.size() != 5) begin n_err++; $display("FAIL bp_emit_count got %0d want 5", emit_log.size()); end
        else for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (emit_log[k] !== ins[k]) begin n_err++; $display("FAIL bp_order slot %0d got %h want %h", k, emit_log[k], ins[k]); end
        end
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 64'h3000;
        cycle();
        in_instr = 32'hFFC00313; in_pc = 64'h3004;
        cycle();
    endtask

    task automatic test_flush();
        fill_two();
        in_instr = 32'h00700393;
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp += 2;
        if (v32 !== 1'b0 || v64 !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b/%b want 0", v32, v64); end
        if (r32 !== 1'b1 || r64 !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b/%b want 1", r32, r64); end
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid();
        fill_two();
        in_instr = 32'h00900493;
        reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        check_reset_values("midreset");
        in_valid = 1'b1; in_instr = 32'h00B00593; in_pc = 64'h4000; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h10, 7'h2B};
        logic [31:0] r;
        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            in_instr  = {r[31:7], ops[$urandom_range(0, 15)]};
            in_pc     = {$urandom(), $urandom()};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
